// File: rtl/lsu_bus_pkg.sv
// lsu_bus_pkg
//   Shared definitions for the load/store bus unit: access-size encodings,
//   the unsigned-load flag value, mem_type bus width, LSU FSM state
//   encoding and the request key captured for each access.
package lsu_bus_pkg;

  localparam int MEM_TYPE_BUS = 2;

  localparam logic [MEM_TYPE_BUS-1:0] LS_B = 2'b00;
  localparam logic [MEM_TYPE_BUS-1:0] LS_H = 2'b01;
  localparam logic [MEM_TYPE_BUS-1:0] LS_W = 2'b10;

  // mem_sign value that selects zero extension on loads
  localparam logic LS_unsigned = 1'b1;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Identity of a request; a level request with an unchanged key has
  // already been served and must not be replayed.
  typedef struct packed {
    logic                    we;
    logic [MEM_TYPE_BUS-1:0] mem_type;
    logic                    sign;
    logic [31:0]             addr;
  } lsu_key_t;

endpackage

// File: rtl/lsu_bus_align.sv
// lsu_align
//   Purely combinational byte-lane logic for the load/store unit.
//   Ports:
//     mem_type  in  access size (LS_B / LS_H / LS_W)
//     mem_sign  in  1 = zero-extend loads, 0 = sign-extend
//     addr_lo   in  addr[1:0] of the access
//     wdata     in  store data, LSBs significant
//     bus_rdata in  raw word read from the bus
//     be        out byte enables for the access
//     wdata_rep out store data replicated across all lanes
//     rdata_ext out load data shifted down and extended
//     misaligned out access not naturally aligned
module lsu_align
  import lsu_bus_pkg::*;
(
  input  logic [MEM_TYPE_BUS-1:0] mem_type,
  input  logic                    mem_sign,
  input  logic [1:0]              addr_lo,
  input  logic [31:0]             wdata,
  input  logic [31:0]             bus_rdata,
  output logic [3:0]              be,
  output logic [31:0]             wdata_rep,
  output logic [31:0]             rdata_ext,
  output logic                    misaligned
);

  logic [31:0] shifted;

  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = shifted;
    misaligned = 1'b0;
    case (mem_type)
      LS_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (mem_sign == LS_unsigned) ? {24'b0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      LS_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = (mem_sign == LS_unsigned) ? {16'b0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      // Word, and the unused encoding treated as word
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// lsu_bus
//   Load/store bus unit for the multicycle core. Captures a level request
//   from the decoder, runs one req/ack transaction on the data bus, aligns
//   and extends load data, flags misaligned or failed accesses and holds
//   the core via stall until the access is complete.
//   Ports:
//     clk, rstn            clock, asynchronous active-low reset
//     rmem, wmem           read / write request levels (wmem wins)
//     mem_type, mem_sign   access size and load extension
//     addr, wdata          byte address and store data
//     rdata, mem_err       load result and fault flag, valid in DONE
//     stall                core must hold its state
//     bus_req/we/addr/be/wdata  registered bus request outputs
//     bus_rdata/ack/err    bus response
//   Build option: define LSU_TIMEOUT_EN to abort a REQ that has waited
//   TIMEOUT_CYCLES cycles without an ack, reporting mem_err.
module lsu_bus
  import lsu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rmem,
  input  logic                    wmem,
  input  logic [MEM_TYPE_BUS-1:0] mem_type,
  input  logic                    mem_sign,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    mem_err,
  output logic                    stall,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [31:0]             bus_addr,
  output logic [3:0]              bus_be,
  output logic [31:0]             bus_wdata,
  input  logic [31:0]             bus_rdata,
  input  logic                    bus_ack,
  input  logic                    bus_err
);

  lsu_state_e state_q, state_d;
  lsu_key_t   key_q, key_d, key_in;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_err_q, mem_err_d;

  logic req_present;
  logic key_match;
  logic capture;
  logic timeout;

  // Aligner inputs: the captured key while a transaction is outstanding
  // (to shape the returning data), otherwise the incoming request (to
  // build the bus outputs registered at capture).
  logic [MEM_TYPE_BUS-1:0] al_type;
  logic                    al_sign;
  logic [1:0]              al_addr_lo;
  logic [3:0]              al_be;
  logic [31:0]             al_wdata;
  logic [31:0]             al_rdata;
  logic                    al_misaligned;

  assign req_present = rmem | wmem;
  assign key_in      = {wmem, mem_type, mem_sign, addr};
  assign key_match   = (key_in == key_q);

  assign al_type    = (state_q == LSU_REQ) ? key_q.mem_type  : mem_type;
  assign al_sign    = (state_q == LSU_REQ) ? key_q.sign      : mem_sign;
  assign al_addr_lo = (state_q == LSU_REQ) ? key_q.addr[1:0] : addr[1:0];

  lsu_align u_align (
    .mem_type   (al_type),
    .mem_sign   (al_sign),
    .addr_lo    (al_addr_lo),
    .wdata      (wdata),
    .bus_rdata  (bus_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts REQ cycles already spent; any cycle outside REQ clears it, so
  // it is zero on every entry into REQ.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == LSU_REQ && !bus_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] timeout_cycles_unused;

  assign timeout_cycles_unused = 32'(TIMEOUT_CYCLES);
  assign timeout               = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    mem_err_d   = mem_err_q;
    capture     = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        capture = req_present;
      end
      LSU_REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          mem_err_d = bus_err;
          if (!key_q.we) begin
            rdata_d = al_rdata;
          end
          state_d = LSU_DONE;
        end else if (timeout) begin
          bus_req_d = 1'b0;
          mem_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (!req_present) begin
          state_d = LSU_IDLE;
        end else begin
          // A changed key is a new access; start it straight from DONE
          capture = !key_match;
        end
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase

    if (capture) begin
      key_d = key_in;
      if (al_misaligned) begin
        state_d   = LSU_DONE;
        bus_req_d = 1'b0;
        mem_err_d = 1'b1;
        rdata_d   = '0;
      end else begin
        state_d     = LSU_REQ;
        bus_req_d   = 1'b1;
        bus_we_d    = wmem;
        bus_addr_d  = {addr[31:2], 2'b00};
        // Reads leave all byte enables low; the full word is returned
        bus_be_d    = wmem ? al_be : 4'b0000;
        bus_wdata_d = al_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= LSU_IDLE;
      key_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // The served-request exemption applies only in DONE with the same key
  assign stall = rstn & req_present & !((state_q == LSU_DONE) && key_match);

  assign rdata     = rdata_q;
  assign mem_err   = mem_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus
//   Self-checking bench for lsu_bus: reset values, a vector table of
//   loads/stores, hand-written multi-cycle sequences (unsolicited ack,
//   back-to-back level requests, reset mid-transaction, missing ack) and
//   randomized transactions checked against a behavioural model.
module tb_lsu_bus;

  logic        clk;
  logic        rstn;
  logic        rmem;
  logic        wmem;
  logic [1:0]  mem_type;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_err;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'h0;

  lsu_bus #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rmem      (rmem),
    .wmem      (wmem),
    .mem_type  (mem_type),
    .mem_sign  (mem_sign),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .mem_err   (mem_err),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the active edge, outputs are sampled at the
  // following falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_mis(input logic [1:0] mt, input logic [31:0] ad);
    if (mt == 2'b01) return (ad % 2) != 0;
    if (mt == 2'b10) return (ad % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [1:0] mt, input logic [31:0] ad);
    int off;
    off = int'(ad % 4);
    if (!we) return 4'h0;
    if (mt == 2'b00) return 4'(1 << off);
    if (mt == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] mt, input logic [31:0] wd);
    if (mt == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (mt == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] mt, input logic sg,
                                             input logic [31:0] ad, input logic [31:0] brd);
    logic [31:0] v;
    logic [31:0] top;
    v = brd >> (8 * (ad % 4));
    if (mt == 2'b10) return v;
    top = (mt == 2'b00) ? 32'h80 : 32'h8000;
    v   = v % (2 * top);
    if (!sg && v >= top) v = v - 2 * top;
    return v;
  endfunction

  // One complete transaction from IDLE back to IDLE, with bus handshakes.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] mt, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] brd,
                        input int wt, input logic berr, input logic exp_mis,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    step();
    rmem = !we; wmem = we; mem_type = mt; mem_sign = sg; addr = ad; wdata = wd;
    bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, " stall_c0"}, 32'(stall), 32'h1);
    if (exp_mis) begin
      step();
      @(negedge clk);
      chk({tag, " mis_bus_req"}, 32'(bus_req), 32'h0);
      chk({tag, " mis_stall"}, 32'(stall), 32'h0);
    end else begin
      for (int c = 1; c <= wt + 1; c++) begin
        step();
        if (c == wt + 1) begin
          bus_ack = 1'b1; bus_err = berr; bus_rdata = brd;
        end else begin
          bus_ack = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
        end
        @(negedge clk);
        chk({tag, " bus_req"}, 32'(bus_req), 32'h1);
        chk({tag, " stall_req"}, 32'(stall), 32'h1);
        chk({tag, " bus_addr"}, bus_addr, ad & 32'hFFFF_FFFC);
        chk({tag, " bus_we"}, 32'(bus_we), 32'(we));
        chk({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
        if (we) chk({tag, " bus_wdata"}, bus_wdata, exp_wd);
      end
      step();
      bus_ack = 1'b0; bus_err = 1'b0;
      @(negedge clk);
      chk({tag, " done_bus_req"}, 32'(bus_req), 32'h0);
      chk({tag, " done_stall"}, 32'(stall), 32'h0);
    end
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " mem_err"}, 32'(mem_err), 32'(exp_err));
    step();
    rmem = 1'b0; wmem = 1'b0;
    @(negedge clk);
    chk({tag, " idle_stall"}, 32'(stall), 32'h0);
    $display("txn %s we=%0d type=%0d addr=%h rdata=%h mem_err=%0d", tag, we, mt, ad, rdata, mem_err);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  mt;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] brd;
    int          wt;
    logic        berr;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int hi;
    // we  mt  sg  addr   wdata  bus_rdata  wait berr mis be  wdata_out  rdata  err
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 3, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0000_8001, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'hAB, 32'h5555_5555, 1, 1'b0, 1'b0, 4'h2, 32'hABAB_ABAB, 32'h0000_8001, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 0, 1'b0, 1'b0, 4'hC, 32'h1234_1234, 32'h0000_8001, 1'b0};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h002, 32'h0, 32'hFEDC_0000, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'hFFFF_FEDC, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h001, 32'h0, 32'h0000_F100, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0000_00F1, 1'b0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h008, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h00C, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 1'b0, 4'hF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h103, 32'h9999, 32'h0, 0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h003, 32'h1234_5677, 32'h0, 2, 1'b1, 1'b0, 4'h8, 32'h7777_7777, 32'h0, 1'b1};

    rstn = 1'b0; rmem = 1'b1; wmem = 1'b0; mem_type = 2'd2; mem_sign = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;

    // ---- reset values (request held high to see stall forced low) ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'h0);
    chk("rst bus_req", 32'(bus_req), 32'h0);
    chk("rst bus_we", 32'(bus_we), 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_be", 32'(bus_be), 32'h0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst mem_err", 32'(mem_err), 32'h0);
    rmem = 1'b0;
    rstn = 1'b1;

    // ---- vector table ----
    for (int i = 0; i < 11; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].mt, vecs[i].sg, vecs[i].ad, vecs[i].wd,
             vecs[i].brd, vecs[i].wt, vecs[i].berr, vecs[i].mis, vecs[i].be, vecs[i].wdo,
             vecs[i].rd, vecs[i].err);
    end
    last_rdata = 32'h0;

    // ---- misaligned LW with an unsolicited ack ----
    step();
    rmem = 1'b1; mem_type = 2'd2; mem_sign = 1'b0; addr = 32'h006;
    bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("unsol stall_c0", 32'(stall), 32'h1);
    chk("unsol bus_req_c0", 32'(bus_req), 32'h0);
    for (int c = 1; c <= 2; c++) begin
      step();
      @(negedge clk);
      chk("unsol bus_req", 32'(bus_req), 32'h0);
      chk("unsol mem_err", 32'(mem_err), 32'h1);
      chk("unsol rdata", rdata, 32'h0);
      chk("unsol stall", 32'(stall), 32'h0);
    end
    step();
    rmem = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    $display("txn unsolicited-ack misaligned LW addr=%h mem_err=%0d", addr, mem_err);

    // ---- back-to-back level requests, no IDLE bubble ----
    step();
    rmem = 1'b1; mem_type = 2'd2; addr = 32'h0;
    @(negedge clk);
    chk("b2b stall_c0", 32'(stall), 32'h1);
    step();
    bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = 32'h0246_8ACE;
    @(negedge clk);
    chk("b2b bus_req0", 32'(bus_req), 32'h1);
    chk("b2b bus_addr0", bus_addr, 32'h0);
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("b2b stall_done0", 32'(stall), 32'h0);
    chk("b2b rdata0", rdata, 32'h0246_8ACE);
    step();
    @(negedge clk);
    chk("b2b hold_stall", 32'(stall), 32'h0);
    chk("b2b hold_bus_req", 32'(bus_req), 32'h0);
    step();
    addr = 32'h4;
    @(negedge clk);
    chk("b2b newkey_stall", 32'(stall), 32'h1);
    step();
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("b2b bus_req1", 32'(bus_req), 32'h1);
    chk("b2b bus_addr1", bus_addr, 32'h4);
    step();
    bus_ack = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    chk("b2b stall_done1", 32'(stall), 32'h0);
    chk("b2b mem_err1", 32'(mem_err), 32'h1);
    chk("b2b rdata1", rdata, 32'h1357_9BDF);
    step();
    rmem = 1'b0;
    @(negedge clk);
    $display("txn back-to-back fetch 0x0 then 0x4 mem_err=%0d", mem_err);

    // ---- reset asserted mid-REQ ----
    step();
    rmem = 1'b1; mem_type = 2'd2; addr = 32'h10;
    step();
    @(negedge clk);
    chk("rstmid bus_req_before", 32'(bus_req), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid bus_req", 32'(bus_req), 32'h0);
    chk("rstmid stall", 32'(stall), 32'h0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF; rmem = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      bus_ack = (c == 0);
      @(negedge clk);
      chk("rstmid after_bus_req", 32'(bus_req), 32'h0);
      chk("rstmid after_rdata", rdata, 32'h0);
      chk("rstmid after_mem_err", 32'(mem_err), 32'h0);
    end
    bus_ack = 1'b0;
    last_rdata = 32'h0;
    $display("txn reset mid-request bus_req=%0d", bus_req);

    // ---- no ack: timeout when enabled, indefinite wait otherwise ----
    step();
    rmem = 1'b1; mem_type = 2'd2; addr = 32'h20;
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      if (bus_req) hi++;
    end
`ifdef LSU_TIMEOUT_EN
    chk("timeout req_cycles", 32'(hi), 32'd16);
    chk("timeout mem_err", 32'(mem_err), 32'h1);
    chk("timeout rdata", rdata, 32'h0);
    chk("timeout stall", 32'(stall), 32'h0);
    last_rdata = 32'h0;
`else
    chk("noack req_cycles", 32'(hi), 32'd40);
    chk("noack stall", 32'(stall), 32'h1);
    step();
    bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("noack rdata", rdata, 32'h5A5A_5A5A);
    chk("noack mem_err", 32'(mem_err), 32'h0);
    last_rdata = 32'h5A5A_5A5A;
`endif
    step();
    rmem = 1'b0;
    @(negedge clk);
    $display("txn no-ack request cycles with bus_req=%0d", hi);

    // ---- randomized transactions against the model ----
    for (int n = 0; n < 60; n++) begin
      logic        r_we, r_sg, r_berr, r_mis;
      logic [1:0]  r_mt;
      logic [31:0] r_ad, r_wd, r_brd, r_rd;
      int          r_wt;
      r_we   = 1'($urandom);
      r_mt   = 2'($urandom_range(0, 2));
      r_sg   = 1'($urandom);
      r_ad   = $urandom;
      r_wd   = $urandom;
      r_brd  = $urandom;
      r_wt   = int'($urandom_range(0, 4));
      r_berr = ($urandom_range(0, 7) == 0);
      r_mis  = model_mis(r_mt, r_ad);
      if (r_mis)      r_rd = 32'h0;
      else if (r_we)  r_rd = last_rdata;
      else            r_rd = model_load(r_mt, r_sg, r_ad, r_brd);
      do_txn($sformatf("rnd%0d", n), r_we, r_mt, r_sg, r_ad, r_wd, r_brd, r_wt, r_berr, r_mis,
             model_be(r_we, r_mt, r_ad), model_wdata(r_mt, r_wd), r_rd, r_mis | r_berr);
      last_rdata = r_rd;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus.md
# lsu_bus

Load/store bus unit for the multicycle nano_riscv core, directly downstream of the control decoder. It consumes `rmem`/`wmem`/`mem_type`/`mem_sign` and the ALU-computed address, and runs a req/ack transaction on the data bus. It performs byte-lane alignment, load sign/zero extension and misalignment checks, and drives `stall` back to freeze the core's state ring until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 16 — max REQ cycles without ack before a bus error is forced (only with `LSU_TIMEOUT_EN`).
- `clk` in 1 — clock.
- `rstn` in 1 — reset, asynchronous, active-low.
- `rmem` in 1 — read request (level).
- `wmem` in 1 — write request (level).
- `mem_type` in 2 — 00 byte, 01 half, 10 word.
- `mem_sign` in 1 — 1 zero-extend (unsigned), 0 sign-extend; loads only.
- `addr` in 32 — byte address.
- `wdata` in 32 — store data, LSBs significant.
- `rdata` out 32 — aligned and extended load data; valid in DONE.
- `mem_err` out 1 — access faulted (misaligned, bus error, or timeout); valid in DONE.
- `stall` out 1 — core must hold its current state.
- `bus_req` out 1 — transaction request.
- `bus_we` out 1 — write strobe.
- `bus_addr` out 32 — word-aligned address, {addr[31:2],2'b00}.
- `bus_be` out 4 — byte enables.
- `bus_wdata` out 32 — lane-replicated store data.
- `bus_rdata` in 32 — read data.
- `bus_ack` in 1 — transaction complete.
- `bus_err` in 1 — transaction failed; qualified by `bus_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- Request key = {wmem, mem_type, mem_sign, addr}. A request is present when rmem|wmem; wmem has priority if both are high.
- IDLE → REQ on a present request; the key is captured.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0): go directly to DONE with mem_err=1, rdata=0. No bus_req is issued.
- REQ: bus_req=1; bus outputs are driven from the captured key.
  - On bus_ack: latch the aligned rdata (reads), latch mem_err=bus_err, then go to DONE.
  - bus_ack while bus_req=0 is ignored.
- DONE: rdata and mem_err are held stable.
  - Present request whose key matches the captured key: stay in DONE (level request already served).
  - No request present: go to IDLE.
  - Present request with a different key: capture it and go to REQ (or DONE if misaligned) the next cycle, with no IDLE bubble.
- stall = present request and not (state==DONE and key matches). stall is forced to 0 while rstn is low.
- Byte enables:
  - B: 0001 shifted left by addr[1:0].
  - H: addr[1] ? 1100 : 0011.
  - W: 1111.
- Store data: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes wdata through.
- Load data: bus_rdata >> (8·addr[1:0]), masked to 8/16/32 bits, then extended per mem_sign. bus_rdata is ignored for writes and rdata is left at its previous value.

## Timing
- Reset values: state IDLE; bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, mem_err all 0.
- Async reset mid-transaction: bus_req drops immediately, no retry after release, and any in-flight ack is ignored.
- All bus_* outputs are registered.
- Latency, with request first seen at cycle 0:
  - bus_req rises at cycle 1.
  - Ack at cycle k≥1 → DONE at k+1, stall low at k+1.
  - Zero-wait ack: stall is high for cycles 0–1 and data is valid at cycle 2.
- Misaligned request: stall is high for cycle 0 only; DONE with mem_err at cycle 1.
- bus_addr, bus_be, bus_we and bus_wdata are stable for the entire time bus_req=1.

## Configuration
- `LSU_TIMEOUT_EN` defined: a REQ-cycle counter is cleared on entering REQ. When it reaches `TIMEOUT_CYCLES` with no ack, bus_req drops, mem_err=1, rdata=0, and the FSM goes to DONE.
- `LSU_TIMEOUT_EN` undefined: no counter; REQ waits for bus_ack indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- The shared defines header holds `LS_B`, `LS_H`, `LS_W`, `LS_unsigned`, the `mem_type_bus` width, and the LSU state encodings.
- One combinational sub-module, `lsu_align`: inputs are mem_type, mem_sign, addr[1:0], wdata and bus_rdata; outputs are bus_be, lane-replicated wdata, extended rdata, and a misaligned flag.
- The FSM, key capture and timeout counter live in `lsu_bus`.

## Test plan
- LB at addr 0x103, bus_rdata=0x80FF_1234, zero-wait ack → bus_addr=0x100, bus_be=0000 (read), rdata=0xFFFF_FF80, mem_err=0, stall high for 2 cycles.
- LHU at addr 0x202, bus_rdata=0x8001_0000, ack after 3 wait cycles → rdata=0x0000_8001, stall deasserts the cycle after ack.
- SB at 0x101 with wdata=0x0000_00AB → bus_we=1, bus_be=0010, bus_wdata=0xABAB_ABAB. SH at 0x102 with wdata=0x1234 → bus_be=1100, bus_wdata=0x1234_1234.
- LW at 0x006 → no bus_req, mem_err=1 and rdata=0 at cycle 1; ack driven unsolicited is ignored.
- Instruction fetch at 0x0 completes into DONE, rmem stays high, then addr changes to 0x4 → new REQ next cycle, no IDLE bubble; bus_err=1 on that ack → mem_err=1.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no ack → bus_req drops after 16 REQ cycles, mem_err=1. Separately, assert rstn low mid-REQ → bus_req=0 immediately and state IDLE.
